// File: rtl/z80_prefetch_queue.sv
// z80_prefetch_queue: instruction fetcher with a DEPTH-entry PC-tagged opcode FIFO toward the decoder.
// Define PREFETCH_STATS_EN to add saturating flush_cnt/drop_cnt outputs.
module z80_prefetch_queue #(
   parameter int ADDR_W        = 16,
   parameter int DATA_W        = 8,
   parameter int DEPTH         = 4,
   parameter int WARMUP_CYCLES = 7,
   parameter int RESET_PC      = 0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              flush,
   input  logic [ADDR_W-1:0] targetPC,
   output logic              MREQ,
   output logic [ADDR_W-1:0] I_Addr,
   input  logic              I_wait,
   input  logic [DATA_W-1:0] I_Data,
   output logic              q_valid,
   output logic [DATA_W-1:0] q_data,
   output logic [ADDR_W-1:0] q_pc,
   input  logic              dec_pop
`ifdef PREFETCH_STATS_EN
   ,
   output logic [15:0]       flush_cnt,
   output logic [15:0]       drop_cnt
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int WW = $clog2(WARMUP_CYCLES) + 1;
   typedef enum logic {WARM, RUN} state_t;
   state_t            state, state_nxt;
   logic [WW-1:0]     warm_cnt;
   logic [CW-1:0]     count, count_nxt;
   logic [PW-1:0]     rd_ptr, wr_ptr;
   logic [DATA_W-1:0] mem_data [DEPTH];
   logic [ADDR_W-1:0] mem_pc [DEPTH];
   logic              xfer, push, pop, clr, warm_done, mreq_nxt;
   logic [ADDR_W-1:0] addr_nxt;
   assign q_valid = count != '0;
   assign q_data  = mem_data[rd_ptr];
   assign q_pc    = mem_pc[rd_ptr];
   // A RUN-state flush discards both the returning byte and any pop on the same edge.
   always_comb begin
      warm_done = state == WARM && warm_cnt == WW'(WARMUP_CYCLES - 1);
      clr       = state == RUN && flush;
      xfer      = MREQ && !I_wait;
      push      = xfer && !clr;
      pop       = q_valid && dec_pop && !clr;
      count_nxt = clr ? '0 : count + CW'(push) - CW'(pop);
      state_nxt = warm_done ? RUN : state;
      mreq_nxt  = state_nxt == RUN && count_nxt < CW'(DEPTH);
      addr_nxt  = flush ? targetPC : push ? I_Addr + ADDR_W'(1) : I_Addr;
   end
   always_ff @(posedge CLK or posedge RST)
      if (RST) state <= WARM;
      else     state <= state_nxt;
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         warm_cnt <= '0;
         MREQ     <= 1'b0;
         I_Addr   <= ADDR_W'(RESET_PC);
         count    <= '0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_data[i] <= '0;
            mem_pc[i]   <= '0;
         end
      end else begin
         warm_cnt <= state == WARM ? warm_cnt + WW'(1) : warm_cnt;
         MREQ     <= mreq_nxt;
         I_Addr   <= addr_nxt;
         count    <= count_nxt;
         rd_ptr   <= clr ? '0 : pop ? rd_ptr + PW'(1) : rd_ptr;
         wr_ptr   <= clr ? '0 : push ? wr_ptr + PW'(1) : wr_ptr;
         if (push) begin
            mem_data[wr_ptr] <= I_Data;
            mem_pc[wr_ptr]   <= I_Addr;
         end
      end
`ifdef PREFETCH_STATS_EN
   logic [16:0] drop_sum;
   assign drop_sum = {1'b0, drop_cnt} + 17'(count) + 17'(xfer);
   always_ff @(posedge CLK or posedge RST)
      if (RST) begin
         flush_cnt <= '0;
         drop_cnt  <= '0;
      end else if (clr) begin
         flush_cnt <= flush_cnt + 16'(flush_cnt != 16'hFFFF);
         drop_cnt  <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
      end
`endif
endmodule

// File: tb/tb_z80_prefetch_queue.sv
// tb_z80_prefetch_queue: directed stimulus with a scoreboard of expected popped bytes.
module tb_z80_prefetch_queue;
   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        flush = 1'b0;
   logic [15:0] targetPC = '0;
   logic        MREQ;
   logic [15:0] I_Addr;
   logic        I_wait = 1'b0;
   logic [7:0]  I_Data;
   logic        q_valid;
   logic [7:0]  q_data;
   logic [15:0] q_pc;
   logic        dec_pop = 1'b0;
`ifdef PREFETCH_STATS_EN
   logic [15:0] flush_cnt, drop_cnt;
`endif
   int vectors = 0;
   int miscompares = 0;
   logic [23:0] exp_q[$];

   z80_prefetch_queue dut (
      .CLK(CLK), .RST(RST), .flush(flush), .targetPC(targetPC),
      .MREQ(MREQ), .I_Addr(I_Addr), .I_wait(I_wait), .I_Data(I_Data),
      .q_valid(q_valid), .q_data(q_data), .q_pc(q_pc), .dec_pop(dec_pop)
`ifdef PREFETCH_STATS_EN
      , .flush_cnt(flush_cnt), .drop_cnt(drop_cnt)
`endif
   );

   always #5 CLK = ~CLK;
   // Memory model: every address returns 0xA0 + low address byte.
   always_comb I_Data = 8'hA0 + I_Addr[7:0];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic expect_byte(input logic [15:0] pc);
      logic [7:0] d;
      d = 8'hA0 + pc[7:0];
      exp_q.push_back({d, pc});
   endtask

   // Monitor: every byte the decoder consumes is checked against the scoreboard.
   always @(negedge CLK) begin
      logic [23:0] e;
      if (!RST && dec_pop && !flush) begin
         if (!q_valid) chk("pop_valid", {31'b0, q_valid}, 32'd1);
         else if (exp_q.size() == 0) chk("pop_unexpected", {8'b0, q_data, q_pc}, 32'hFFFFFFFF);
         else begin
            e = exp_q.pop_front();
            chk("pop_byte", {8'b0, q_data, q_pc}, {8'b0, e});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1);
   end

   initial begin
      #1;
      chk("rst_mreq", MREQ, 0);
      chk("rst_addr", I_Addr, 0);
      chk("rst_qvalid", q_valid, 0);
      chk("rst_qdata", q_data, 0);
      chk("rst_qpc", q_pc, 0);
      tick();
      RST = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("warm_mreq", MREQ, (i == 7) ? 1 : 0);
         if (i < 7) tick();
      end
      chk("warm_addr", I_Addr, 16'h0000);
      for (int a = 0; a <= 16'h10; a++) expect_byte(16'(a));
      repeat (4) tick();
      chk("full_mreq", MREQ, 0);
      chk("full_addr", I_Addr, 16'h0004);
      chk("full_qvalid", q_valid, 1);
      chk("full_qdata", q_data, 8'hA0);
      chk("full_qpc", q_pc, 16'h0000);
      dec_pop = 1'b1;
      for (int i = 0; i < 13; i++) begin
         tick();
         chk("stream_mreq", MREQ, 1);
      end
      chk("stream_addr", I_Addr, 16'h0010);
      dec_pop = 1'b0;
      I_wait = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("wait_mreq", MREQ, 1);
         chk("wait_addr", I_Addr, 16'h0010);
         chk("wait_head", q_pc, 16'h000D);
      end
      I_wait = 1'b0;
      tick();
      chk("wait_end_mreq", MREQ, 0);
      chk("wait_end_addr", I_Addr, 16'h0011);
      dec_pop = 1'b1;
      tick();
      I_wait = 1'b1;
      tick();
      chk("prefl_mreq", MREQ, 1);
      chk("prefl_addr", I_Addr, 16'h0011);
      dec_pop = 1'b0;
      I_wait = 1'b0;
      flush = 1'b1;
      targetPC = 16'h1234;
      exp_q.delete();
      tick();
      flush = 1'b0;
      chk("flush_qvalid", q_valid, 0);
      chk("flush_addr", I_Addr, 16'h1234);
      chk("flush_mreq", MREQ, 1);
`ifdef PREFETCH_STATS_EN
      chk("flush_cnt1", flush_cnt, 1);
      chk("drop_cnt1", drop_cnt, 3);
`endif
      tick();
      chk("post_flush_qvalid", q_valid, 1);
      chk("post_flush_qpc", q_pc, 16'h1234);
      chk("post_flush_qdata", q_data, 8'hD4);
      chk("post_flush_addr", I_Addr, 16'h1235);
      flush = 1'b1;
      targetPC = 16'hFFFE;
      tick();
      flush = 1'b0;
      chk("wrap_qvalid", q_valid, 0);
      chk("wrap_addr", I_Addr, 16'hFFFE);
      chk("wrap_mreq", MREQ, 1);
`ifdef PREFETCH_STATS_EN
      chk("flush_cnt2", flush_cnt, 2);
      chk("drop_cnt2", drop_cnt, 5);
`endif
      expect_byte(16'hFFFE);
      expect_byte(16'hFFFF);
      expect_byte(16'h0000);
      expect_byte(16'h0001);
      repeat (4) tick();
      chk("wrap_full_mreq", MREQ, 0);
      chk("wrap_full_addr", I_Addr, 16'h0002);
      dec_pop = 1'b1;
      repeat (4) tick();
      dec_pop = 1'b0;
      chk("drain_done", exp_q.size(), 0);
      chk("pre_rst_qvalid", q_valid, 1);
      #2;
      RST = 1'b1;
      #1;
      chk("arst_mreq", MREQ, 0);
      chk("arst_addr", I_Addr, 0);
      chk("arst_qvalid", q_valid, 0);
      chk("arst_qdata", q_data, 0);
      chk("arst_qpc", q_pc, 0);
`ifdef PREFETCH_STATS_EN
      chk("arst_flush_cnt", flush_cnt, 0);
      chk("arst_drop_cnt", drop_cnt, 0);
`endif
      tick();
      RST = 1'b0;
      repeat (3) tick();
      chk("rewarm_mreq", MREQ, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
